// File: rtl/cnn_pkg.sv
// Shared constants, types and helpers for the streaming CNN pipeline stages.
package cnn_pkg;

    localparam int CNN_WORD_SIZE    = 8;
    localparam int CNN_ROW_SIZE     = 540;
    localparam int CNN_IMAGE_HEIGHT = 360;

    // pix_max is written at a fixed wide width; callers zero-extend their pixels.
    localparam int PIX_MAX_W = 32;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } pool_state_t;

    function automatic logic [PIX_MAX_W-1:0] pix_max(
        input logic [PIX_MAX_W-1:0] a,
        input logic [PIX_MAX_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_2x2_if.sv
// Pixel stream interface between the convolution stage and the 2x2 max-pool stage.
interface max_pool_2x2_if
    import cnn_pkg::*;
#(
    parameter int WORD_SIZE = CNN_WORD_SIZE
);

    logic [WORD_SIZE-1:0] inPixel;
    logic                 inValid;
    logic [WORD_SIZE-1:0] outPixel;
    logic                 outValid;
    logic                 frameEnd;

    modport master (
        output inPixel,
        output inValid,
        input  outPixel,
        input  outValid,
        input  frameEnd
    );

    modport slave (
        input  inPixel,
        input  inValid,
        output outPixel,
        output outValid,
        output frameEnd
    );

endinterface

// File: rtl/pool_line_buffer.sv
// Half-row simple dual-port RAM with a registered read port; no reset so it maps to block RAM.
module pool_line_buffer #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 270,
    parameter int ADDR_W    = 9
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [WORD_SIZE-1:0] rd_data_q;

    // Read data is held while rd_en is low, so input gaps never lose it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a raster pixel stream. Horizontal maxima of each
// even row wait in a half-row line buffer until the matching odd row arrives.
module max_pool_2x2
    import cnn_pkg::*;
#(
    parameter int WORD_SIZE    = CNN_WORD_SIZE,
    parameter int ROW_SIZE     = CNN_ROW_SIZE,
    parameter int IMAGE_HEIGHT = CNN_IMAGE_HEIGHT
) (
    input  logic          clk,
    input  logic          rst,
    max_pool_2x2_if.slave pool
);

    localparam int HALF_ROW = ROW_SIZE / 2;
    localparam int COL_W    = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int ADDR_W   = (HALF_ROW > 1) ? $clog2(HALF_ROW) : 1;

    localparam logic [COL_W-1:0] LAST_COL     = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_W-1:0] LAST_OUT_ROW = ROW_W'(IMAGE_HEIGHT - 1 - (IMAGE_HEIGHT % 2));

    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [ROW_W-1:0]     row_next;
    pool_state_t          state_q, state_d;
    logic [WORD_SIZE-1:0] hold_q, hold_d;
    logic [WORD_SIZE-1:0] out_pixel_q, out_pixel_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_end_q, frame_end_d;

    logic [WORD_SIZE-1:0] hmax;
    logic [WORD_SIZE-1:0] lb_rd_data;
    logic [ADDR_W-1:0]    lb_addr;
    logic                 lb_wr_en;
    logic                 lb_rd_en;

    function automatic logic [WORD_SIZE-1:0] max_w(
        input logic [WORD_SIZE-1:0] a,
        input logic [WORD_SIZE-1:0] b
    );
        return WORD_SIZE'(pix_max(PIX_MAX_W'(a), PIX_MAX_W'(b)));
    endfunction

    assign hmax     = max_w(hold_q, pool.inPixel);
    assign lb_addr  = ADDR_W'(col_q >> 1);
    assign row_next = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        state_d     = state_q;
        hold_d      = hold_q;
        out_pixel_d = out_pixel_q;
        out_valid_d = 1'b0;
        frame_end_d = 1'b0;
        lb_wr_en    = 1'b0;
        lb_rd_en    = 1'b0;

        if (pool.inValid) begin
            if (!col_q[0]) begin
                // Fetch the stored even-row maximum now so it is ready at the odd column.
                hold_d   = pool.inPixel;
                lb_rd_en = 1'b1;
            end else if (state_q == EVEN_ROW) begin
                lb_wr_en = 1'b1;
            end else begin
                out_pixel_d = max_w(lb_rd_data, hmax);
                out_valid_d = 1'b1;
                frame_end_d = (row_q == LAST_OUT_ROW) && (col_q == LAST_COL);
            end

            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_next;
                // A trailing row of an odd-height frame has an even index, so it
                // automatically gets even-row (write-only) behaviour.
                state_d = row_next[0] ? ODD_ROW : EVEN_ROW;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            state_q     <= EVEN_ROW;
            hold_q      <= '0;
            out_pixel_q <= '0;
            out_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_pixel_q <= out_pixel_d;
            out_valid_q <= out_valid_d;
            frame_end_q <= frame_end_d;
        end
    end

    pool_line_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (HALF_ROW),
        .ADDR_W    (ADDR_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (lb_addr),
        .wr_data (hmax),
        .rd_en   (lb_rd_en),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_data)
    );

    assign pool.outPixel = out_pixel_q;
    assign pool.outValid = out_valid_q;
    assign pool.frameEnd = frame_end_q;

endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Streaming 2×2, stride-2 max-pooling stage placed directly downstream of `convolution`. It consumes the convolution output as a raster-order pixel stream, one pixel per valid cycle, and emits one pooled pixel for every 2×2 window. The output image is (ROW_SIZE/2) × (IMAGE_HEIGHT/2). A single half-row line buffer holds the horizontal maxima of each even row until the matching odd row arrives.

## Interface
- `WORD_SIZE`, 8: pixel width in bits; pixels are unsigned.
- `ROW_SIZE`, 540: input pixels per row; must be even.
- `IMAGE_HEIGHT`, 360: input rows per frame; any value ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `inPixel`  in  WORD_SIZE  convolution output pixel.
- `inValid`  in  1  `inPixel` is accepted on any rising edge where this is high; no backpressure.
- `outPixel`  out  WORD_SIZE  pooled pixel.
- `outValid`  out  1  single-cycle qualifier for `outPixel`.
- `frameEnd`  out  1  pulses together with the last pooled pixel of a frame.

## Operation
- Counters:
  - `col` runs 0..ROW_SIZE-1.
  - `row` runs 0..IMAGE_HEIGHT-1.
  - Both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 after IMAGE_HEIGHT-1.
- Horizontal stage: on even `col`, the pixel is latched into `hold`. On odd `col`, `hmax = max(hold, inPixel)`.
- FSM with two states, `EVEN_ROW` and `ODD_ROW`, following `row[0]`:
  - Reset state is `EVEN_ROW`.
  - `EVEN_ROW`: on odd `col`, write `hmax` to `linebuf[col>>1]`. No output.
  - `ODD_ROW`: on odd `col`, `outPixel ← max(linebuf[col>>1], hmax)` and `outValid ← 1`.
  - The state toggles at each row wrap.
  - When IMAGE_HEIGHT is odd, the final row of the frame is forced to `EVEN_ROW` behaviour and its writes are never read. It produces no output. The next frame starts in `EVEN_ROW`.
- `frameEnd` is 1 with the output for `row == IMAGE_HEIGHT - 1 - (IMAGE_HEIGHT%2)` and `col == ROW_SIZE-1`.
- Comparisons are unsigned. Ties select either operand; the value is identical.
- Reset values: `outPixel` = 0, `outValid` = 0, `frameEnd` = 0, counters = 0, `hold` = 0, FSM = `EVEN_ROW`. `linebuf` is not cleared, because every entry is written before it is read.
- Reset mid-frame: the next accepted pixel is treated as row 0, col 0 of a new frame.

## Timing
- Latency: `outValid` rises on the edge after the cycle in which the odd-row, odd-col pixel is accepted, i.e. 1 cycle. `outPixel` is registered.
- `linebuf` read is combinational or registered. If registered, the read address `col>>1` is issued while the even-col pixel is accepted, so the 1-cycle latency holds.
- For `ROW_SIZE` = 540 and continuous `inValid`, odd rows produce one output every 2 cycles; even rows produce none.
- `inValid` gaps of any length are allowed between any two pixels; all state is held.
- `outValid` and `frameEnd` are never high for more than 1 consecutive cycle.
- A row boundary and a frame boundary coinciding with a reset deassertion is legal. The first accepted pixel after reset deasserts is always col 0, row 0.

## Structure
- Shared package `cnn_pkg`: default `WORD_SIZE`, `ROW_SIZE`, `IMAGE_HEIGHT` constants; `pool_state_t` enum {`EVEN_ROW`, `ODD_ROW`}; function `pix_max(a,b)`.
- Sub-module `pool_line_buffer`: simple dual-port RAM, depth ROW_SIZE/2, width WORD_SIZE, one write port and one read port, no reset. Synthesizes to BRAM.
- Top module holds the counters, the FSM, `hold`, and the output registers.

## Test plan
- 4×4 frame (`ROW_SIZE` = 4, `IMAGE_HEIGHT` = 4) with pixels 0..15 in raster order, `inValid` continuous -> outputs 5, 7, 13, 15; `frameEnd` with 15 only.
- Same frame with random `inValid` gaps of 0–5 cycles -> identical output sequence, each output 1 cycle after its triggering pixel.
- Window containing 0xFF, 0x01, 0x80, 0x7F -> 0xFF (unsigned compare).
- `IMAGE_HEIGHT` = 3, `ROW_SIZE` = 4, pixels 0..11 -> outputs 5, 7 only; `frameEnd` with 7. A second frame then yields 5, 7 again.
- Assert `rst` low after 6 pixels of a 4×4 frame, release, then send a full frame 0..15 -> outputs 5, 7, 13, 15 with no stale data.
- Full 540×360 image from `image_data.hex` via `convolution` -> 48,600 outputs matching the golden model; exactly one `frameEnd`.
